dom_gf_mul_pipe: RTL and testbench

//  Masked (domain-oriented) GF(2^BIT_WIDTH) multiplier for the masked S-box datapath.

---
 rtl/aes128_package.sv | 19 +
 rtl/dom_gf_mul_pipe_stage.sv | 33 +++
 rtl/generic_mul.sv | 21 ++
 rtl/dom_gf_mul_pipe.sv | 74 +++++++
 tb/tb_dom_gf_mul_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_package.sv
// aes128_package: shared helpers for the masked S-box datapath (DOM pair indexing, field reduction constants).
package aes128_package;
  localparam int DOM_MIN_SHARES = 2;
  localparam int DOM_MAX_SHARES = 4;
  function automatic int dom_num_random(int d);
    return d * (d - 1) / 2;
  endfunction
  function automatic int dom_pair_index(int i, int j, int d);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction
  // Low-order bits of the reduction polynomial: x+1, x^2+x+1, x^4+x+1.
  function automatic logic [3:0] gf_poly(int w);
    return (w == 1) ? 4'h1 : 4'h3;
  endfunction
endpackage

// File: rtl/dom_gf_mul_pipe_stage.sv
// dom_gf_mul_pipe_stage: one valid/ready register slice; data only moves on a load, reset clears everything.
module dom_gf_mul_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);
  logic          valid_q, valid_d, load;
  logic [DW-1:0] data_q, data_d;
  assign ready_o = !valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  always_comb begin
    load    = valid_i & ready_o;
    valid_d = load | (valid_q & !ready_i);
    data_d  = load ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/generic_mul.sv
// generic_mul: combinational GF(2^W) polynomial-basis multiplier for W = 1, 2 or 4.
module generic_mul
  import aes128_package::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] c_o
);
  localparam logic [W-1:0] RED = W'(gf_poly(W));
  logic [W-1:0] p;
  always_comb begin
    c_o = '0;
    p = a_i;
    for (int k = 0; k < W; k++) begin
      c_o = c_o ^ (b_i[k] ? p : '0);
      p = p[W-1] ? ((p << 1) ^ RED) : (p << 1);
    end
  end
endmodule

// File: rtl/dom_gf_mul_pipe.sv
// dom_gf_mul_pipe: domain-oriented masked GF(2^BIT_WIDTH) multiplier, two elastic pipeline stages.
module dom_gf_mul_pipe
  import aes128_package::*;
#(
  parameter int BIT_WIDTH = 2,
  parameter int NUM_SHARES = 2,
  localparam int NUM_RANDOM = dom_num_random(NUM_SHARES)
) (
  input  logic                                  in_clock,
  input  logic                                  in_reset,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_a,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_b,
  input  logic [NUM_RANDOM-1:0][BIT_WIDTH-1:0]  in_random,
  input  logic                                  in_valid,
  output logic                                  out_ready,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  out_c,
  output logic                                  out_valid,
  input  logic                                  in_ready
);
  localparam int NT = NUM_SHARES * NUM_SHARES;
  typedef logic [BIT_WIDTH-1:0] T;
  typedef T [NUM_SHARES-1:0] shares_t;
  typedef T [NT-1:0] terms_t;
  if (!(BIT_WIDTH == 1 || BIT_WIDTH == 2 || BIT_WIDTH == 4)) begin : g_bad_width
    $fatal(1, "dom_gf_mul_pipe: BIT_WIDTH must be 1, 2 or 4");
  end
  if (NUM_SHARES < DOM_MIN_SHARES || NUM_SHARES > DOM_MAX_SHARES) begin : g_bad_shares
    $fatal(1, "dom_gf_mul_pipe: NUM_SHARES must be in 2..4");
  end
  terms_t  prod, t_d, t_q;
  shares_t c_d;
  logic    s1_valid, s1_ready;
  // Cross terms are only re-masked here; shares from different domains meet after the stage-1 register.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
      generic_mul #(.W(BIT_WIDTH)) u_mul (
        .a_i(in_a[i]),
        .b_i(in_b[j]),
        .c_o(prod[i*NUM_SHARES+j])
      );
      if (i == j) begin : g_inner
        assign t_d[i*NUM_SHARES+j] = prod[i*NUM_SHARES+j];
      end else begin : g_cross
        assign t_d[i*NUM_SHARES+j] = prod[i*NUM_SHARES+j] ^ in_random[dom_pair_index(i, j, NUM_SHARES)];
      end
    end
  end
  dom_gf_mul_pipe_stage #(.DW($bits(terms_t))) u_s1 (
    .clk    (in_clock),
    .rst    (in_reset),
    .valid_i(in_valid),
    .ready_o(out_ready),
    .data_i (t_d),
    .valid_o(s1_valid),
    .ready_i(s1_ready),
    .data_o (t_q)
  );
  always_comb begin
    c_d = '0;
    for (int i = 0; i < NUM_SHARES; i++)
      for (int j = 0; j < NUM_SHARES; j++)
        c_d[i] = c_d[i] ^ t_q[i*NUM_SHARES+j];
  end
  dom_gf_mul_pipe_stage #(.DW($bits(shares_t))) u_s2 (
    .clk    (in_clock),
    .rst    (in_reset),
    .valid_i(s1_valid),
    .ready_o(s1_ready),
    .data_i (c_d),
    .valid_o(out_valid),
    .ready_i(in_ready),
    .data_o (out_c)
  );
endmodule

// File: tb/tb_dom_gf_mul_pipe.sv
// tb_dom_gf_mul_pipe: directed and scoreboarded checks of the masked multiplier at W=1/d=2 and W=4/d=3.
module tb_dom_gf_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0][0:0] a1, b1, c1;
  logic [0:0][0:0] r1;
  logic v1, rdy1, or1, ov1;
  logic [2:0][3:0] a4, b4, r4, c4;
  logic v4, rdy4, or4, ov4;
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  logic [11:0] exp_q[$], got_q[$], want_q[$];

  dom_gf_mul_pipe #(.BIT_WIDTH(1), .NUM_SHARES(2)) u_dut1 (
    .in_clock(clk), .in_reset(rst), .in_a(a1), .in_b(b1), .in_random(r1), .in_valid(v1),
    .out_ready(or1), .out_c(c1), .out_valid(ov1), .in_ready(rdy1)
  );
  dom_gf_mul_pipe #(.BIT_WIDTH(4), .NUM_SHARES(3)) u_dut4 (
    .in_clock(clk), .in_reset(rst), .in_a(a4), .in_b(b4), .in_random(r4), .in_valid(v4),
    .out_ready(or4), .out_c(c4), .out_valid(ov4), .in_ready(rdy4)
  );

  // GF(16) with x^4+x+1: full carry-less product, then fold the high bits down.
  function automatic logic [3:0] gf16(logic [3:0] a, logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p ^= 7'(a) << i;
    for (int k = 6; k >= 4; k--) if (p[k]) p ^= 7'b0010011 << (k - 4);
    return p[3:0];
  endfunction

  // For d=3 the pair (i,j) uses mask r[i+j-1].
  function automatic logic [11:0] exp_c(logic [2:0][3:0] a, logic [2:0][3:0] b, logic [2:0][3:0] r);
    logic [2:0][3:0] c;
    for (int i = 0; i < 3; i++) begin
      c[i] = '0;
      for (int j = 0; j < 3; j++) begin
        c[i] ^= gf16(a[i], b[j]);
        if (i != j) c[i] ^= r[i+j-1];
      end
    end
    return c;
  endfunction

  function automatic logic [3:0] xs(logic [11:0] c);
    return c[3:0] ^ c[7:4] ^ c[11:8];
  endfunction

  task automatic rand_item();
    a4 = 12'($urandom);
    b4 = 12'($urandom);
    r4 = 12'($urandom);
  endtask

  // Advance one cycle on dut4, logging takes before accepts so same-cycle shifts stay ordered.
  task automatic step();
    #1;
    if (ov4 && rdy4) begin
      got_q.push_back(c4);
      if (exp_q.size() != 0) want_q.push_back(exp_q.pop_front());
      else want_q.push_back(12'hxxx);
    end
    if (v4 && or4) begin
      exp_q.push_back(exp_c(a4, b4, r4));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    v4 = 1'b0;
    rdy4 = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ov4 !== 1'b0 || c4 !== 12'h000 || or4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_d3: valid %b c %h ready %b required 0 000 1", ov4, c4, or4);
    end
    checks++;
    if (ov1 !== 1'b0 || c1 !== 2'b00 || or1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_d2: valid %b c %b ready %b required 0 00 1", ov1, c1, or1);
    end
  endtask

  task automatic test_w1();
    rdy1 = 1'b1;
    a1 = 2'b01;
    b1 = 2'b10;
    r1 = 1'b1;
    v1 = 1'b1;
    #1;
    checks++;
    if (or1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_ready: got %b required 1", or1);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    checks++;
    if (ov1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_early_valid: got %b required 0", ov1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov1 !== 1'b1 || c1 !== 2'b10) begin
      errors++;
      $display("FAIL w1_result: valid %b c %b required 1 10", ov1, c1);
    end
    checks++;
    if ((c1[0] ^ c1[1]) !== 1'b1) begin
      errors++;
      $display("FAIL w1_unmasked: got %b required 1", c1[0] ^ c1[1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_taken: valid %b required 0", ov1);
    end
  endtask

  task automatic test_directed();
    logic [11:0] va[3] = '{12'h008, 12'h00F, 12'h032};
    logic [11:0] vb[3] = '{12'h002, 12'h00F, 12'h004};
    logic [11:0] vr[3] = '{12'h000, 12'h421, 12'h000};
    logic [11:0] vc[3] = '{12'h003, 12'h659, 12'h0C8};
    rdy4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a4 = va[k];
      b4 = vb[k];
      r4 = vr[k];
      v4 = 1'b1;
      step();
    end
    drain();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL directed_count: got %0d required 3", got_q.size());
    end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== vc[k]) begin
        errors++;
        $display("FAIL directed_%0d: got %h required %h", k, got_q[k], vc[k]);
      end
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_stream();
    int n0;
    n0 = n_acc;
    rdy4 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rand_item();
      v4 = 1'b1;
      step();
    end
    checks++;
    if (n_acc - n0 != 1000 || got_q.size() != 998) begin
      errors++;
      $display("FAIL stream_rate: accepts %0d results %0d required 1000 998", n_acc - n0, got_q.size());
    end
    drain();
    checks++;
    if (got_q.size() != 1000) begin
      errors++;
      $display("FAIL stream_count: got %0d required 1000", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== want_q[k]) begin
        errors++;
        $display("FAIL stream_item %0d: got %h required %h", k, got_q[k], want_q[k]);
      end
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_zero();
    for (int k = 0; k < 40; k++) begin
      rand_item();
      b4[2] = b4[0] ^ b4[1];
      v4 = 1'($urandom_range(0, 1));
      rdy4 = 1'($urandom_range(0, 1));
      step();
    end
    drain();
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (xs(got_q[k]) !== 4'h0 || got_q[k] !== want_q[k]) begin
        errors++;
        $display("FAIL zero_item %0d: got %h (xor %h) required %h (xor 0)", k, got_q[k], xs(got_q[k]), want_q[k]);
      end
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_backpressure();
    logic [11:0] hold;
    rdy4 = 1'b0;
    v4 = 1'b1;
    rand_item();
    step();
    rand_item();
    step();
    rand_item();
    hold = c4;
    for (int k = 0; k < 5; k++) begin
      r4 = 12'($urandom);
      #1;
      checks++;
      if (or4 !== 1'b0 || ov4 !== 1'b1 || c4 !== hold) begin
        errors++;
        $display("FAIL stall_%0d: ready %b valid %b c %h required 0 1 %h", k, or4, ov4, c4, hold);
      end
      step();
    end
    rdy4 = 1'b1;
    step();
    drain();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL stall_count: got %0d required 3", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== want_q[k]) begin
        errors++;
        $display("FAIL stall_item %0d: got %h required %h", k, got_q[k], want_q[k]);
      end
    end
    checks++;
    if (got_q.size() == 0 || got_q[0] !== hold) begin
      errors++;
      $display("FAIL stall_head: got %h required %h", got_q.size() != 0 ? got_q[0] : 12'hxxx, hold);
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_reset_mid();
    rdy4 = 1'b0;
    v4 = 1'b1;
    rand_item();
    step();
    rand_item();
    step();
    rand_item();
    rst = 1'b1;
    rdy4 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    v4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || c4 !== 12'h000 || or4 !== 1'b1) begin
      errors++;
      $display("FAIL midreset: valid %b c %h ready %b required 0 000 1", ov4, c4, or4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_override: valid %b required 0", ov4);
    end
    exp_q.delete();
    got_q.delete();
    want_q.delete();
    for (int k = 0; k < 3; k++) begin
      rand_item();
      v4 = 1'b1;
      step();
    end
    drain();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL postreset_count: got %0d required 3", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== want_q[k]) begin
        errors++;
        $display("FAIL postreset_item %0d: got %h required %h", k, got_q[k], want_q[k]);
      end
    end
    got_q.delete();
    want_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {a1, b1, r1, v1, rdy1} = '0;
    {a4, b4, r4, v4, rdy4} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_w1();
    test_directed();
    test_stream();
    test_zero();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
